// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: an operand channel in, a result channel out.
interface alu_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] out_tag;
   logic             flag_z;
   logic             flag_n;
   logic             flag_c;
   logic             flag_v;
   logic             illegal_op;

   modport master (
      output in_valid, a, b, op, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag, flag_z, flag_n, flag_c, flag_v, illegal_op
   );

   modport slave (
      input  in_valid, a, b, op, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag, flag_z, flag_n, flag_c, flag_v, illegal_op
   );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and NZCV flags.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (op 10) and its BUSY state.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
      OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_SRA = 4'd7,
      OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             n;
      logic             c;
      logic             v;
      logic             ill;
   } rsp_t;

   rsp_t             alu, mrsp, q;
   logic             out_valid;
   logic [TAG_W-1:0] out_tag, mul_tag;
   logic             accept, deliver, is_mul, mul_done;
   logic [SHW-1:0]   sh;
   logic [WIDTH:0]   sum, dif;

   assign sh      = bus.b[SHW-1:0];
   assign accept  = bus.in_valid && bus.in_ready;
   assign deliver = out_valid && bus.out_ready;

   always_comb begin
      alu = '0;
      sum = {1'b0, bus.a} + {1'b0, bus.b};
      dif = {1'b0, bus.a} - {1'b0, bus.b};
      case (bus.op)
         OP_ADD: begin
            alu.res = sum[WIDTH-1:0];
            alu.c   = sum[WIDTH];
            alu.v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            // borrow-out of the extended subtract is the inverse of carry
            alu.res = dif[WIDTH-1:0];
            alu.c   = ~dif[WIDTH];
            alu.v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  alu.res = bus.a & bus.b;
         OP_OR:   alu.res = bus.a | bus.b;
         OP_XOR:  alu.res = bus.a ^ bus.b;
         OP_SHL:  alu.res = bus.a << sh;
         OP_SHR:  alu.res = bus.a >> sh;
         OP_SRA:  alu.res = WIDTH'($signed(bus.a) >>> sh);
         OP_SLT:  alu.res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu.res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
`ifdef ALU_MUL_EN
         OP_MUL:  alu.ill = 1'b0;
`endif
         default: alu.ill = 1'b1;
      endcase
      alu.z = (alu.res == '0);
      alu.n = alu.res[WIDTH-1];
   end

`ifdef ALU_MUL_EN
   typedef enum logic {IDLE, BUSY} state_e;
   localparam logic [SHW:0] ITERS = (SHW+1)'(WIDTH);

   state_e             state, state_nxt;
   logic [2*WIDTH-1:0] mcand, acc;
   logic [WIDTH-1:0]   mplier;
   logic [SHW:0]       cnt;

   assign is_mul       = (bus.op == OP_MUL);
   assign mul_done     = (state == BUSY) && (cnt == ITERS);
   assign bus.in_ready = (state == IDLE) && (!out_valid || bus.out_ready);

   always_comb begin
      mrsp     = '0;
      mrsp.res = acc[WIDTH-1:0];
      mrsp.v   = |acc[2*WIDTH-1:WIDTH];
      mrsp.z   = (mrsp.res == '0);
      mrsp.n   = mrsp.res[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && is_mul) state_nxt = BUSY;
         BUSY: if (mul_done)         state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // One multiplier bit per clock; the extra cycle after the last add publishes the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         mul_tag <= '0;
      end else if (accept && is_mul) begin
         mcand   <= {{WIDTH{1'b0}}, bus.a};
         mplier  <= bus.b;
         acc     <= '0;
         cnt     <= '0;
         mul_tag <= bus.in_tag;
      end else if (state == BUSY && !mul_done) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end
`else
   assign is_mul       = 1'b0;
   assign mul_done     = 1'b0;
   assign mrsp         = '0;
   assign mul_tag      = '0;
   assign bus.in_ready = !out_valid || bus.out_ready;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         q         <= '0;
         out_tag   <= '0;
      end else if (mul_done) begin
         q         <= mrsp;
         out_tag   <= mul_tag;
         out_valid <= 1'b1;
      end else if (accept && !is_mul) begin
         q         <= alu;
         out_tag   <= bus.in_tag;
         out_valid <= 1'b1;
      end else if (deliver) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.out_valid  = out_valid;
   assign bus.result     = q.res;
   assign bus.out_tag    = out_tag;
   assign bus.flag_z     = q.z;
   assign bus.flag_n     = q.n;
   assign bus.flag_c     = q.c;
   assign bus.flag_v     = q.v;
   assign bus.illegal_op = q.ill;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32, TAG_W=4); covers the MUL path when ALU_MUL_EN is defined.
module tb_alu_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();
   alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;

   typedef struct packed {
      logic [31:0] r;
      logic [3:0]  t;
      logic        z, n, c, v, i;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   bit   bp_mode = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] tag);
      exp_t        e;
      longint      sa, sbv, d;
      logic [32:0] s;
      logic [63:0] p;
      int          sh;
      e   = '0;
      e.t = tag;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      sh  = int'(b[4:0]);
      case (op)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; e.r = s[31:0]; e.c = s[32];
                     d = sa + sbv; e.v = (d > SMAX) || (d < SMIN); end
         4'd1: begin e.r = a - b; e.c = (a >= b);
                     d = sa - sbv; e.v = (d > SMAX) || (d < SMIN); end
         4'd2: e.r = a & b;
         4'd3: e.r = a | b;
         4'd4: e.r = a ^ b;
         4'd5: e.r = a << sh;
         4'd6: e.r = a >> sh;
         4'd7: e.r = 32'(sa >>> sh);
         4'd8: e.r = (sa < sbv) ? 32'd1 : 32'd0;
         4'd9: e.r = (a < b) ? 32'd1 : 32'd0;
         4'd10: if (MUL_EN) begin
                   p = {32'd0, a} * {32'd0, b};
                   e.r = p[31:0]; e.v = (p[63:32] != 32'd0);
                end else e.i = 1'b1;
         default: e.i = 1'b1;
      endcase
      e.z = (e.r == 32'd0);
      e.n = e.r[31];
      return e;
   endfunction

   function automatic exp_t cur_out();
      exp_t e;
      e = {bus.result, bus.out_tag, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.illegal_op};
      return e;
   endfunction

   // Result-side monitor: pops the scoreboard on each delivery and checks hold-while-stalled.
   exp_t held;
   bit   stall_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_hold", 64'(cur_out()), 64'(held));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("extra_beat", 64'(sb.size()), 64'd1);
            else                chk("beat", 64'(cur_out()), 64'(sb.pop_front()));
         end
         stall_prev <= bus.out_valid && !bus.out_ready;
         held       <= cur_out();
      end
   end

   always @(posedge clk) begin
      #1;
      bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.op = op; bus.a = a; bus.b = b; bus.in_tag = tag;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
      else     sb.push_back(model(op, a, b, tag));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.in_tag = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_outputs", 64'(cur_out()), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(4'd0, 32'hFFFF_FFFF, 32'h1, 4'd3);
      chk("add_latency", 64'(bus.out_valid), 64'd1);
      chk("add_wrap_result", 64'(bus.result), 64'd0);
      send(4'd0, 32'h7FFF_FFFF, 32'h1, 4'd1);
      send(4'd1, 32'd5, 32'd7, 4'd2);
      send(4'd1, 32'd7, 32'd5, 4'd4);
      send(4'd1, 32'h8000_0000, 32'd1, 4'd5);
      send(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd6);
      send(4'd3, 32'hF000_0000, 32'h0000_000F, 4'd7);
      send(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 4'd8);
      send(4'd5, 32'h0000_0001, 32'hFFFF_FFE5, 4'd9);
      send(4'd6, 32'h8000_0000, 32'h0000_0024, 4'd10);
      send(4'd7, 32'h8000_0000, 32'h0000_0024, 4'd11);
      send(4'd7, 32'h4000_0000, 32'h0000_0004, 4'd12);
      send(4'd8, 32'hFFFF_FFFF, 32'h1, 4'd13);
      send(4'd9, 32'hFFFF_FFFF, 32'h1, 4'd14);
      send(4'd8, 32'h1, 32'hFFFF_FFFF, 4'd15);
      send(4'd9, 32'h1, 32'hFFFF_FFFF, 4'd0);
      send(4'd15, 32'h1234_5678, 32'h1, 4'd1);
      send(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
`ifndef ALU_MUL_EN
      send(4'd10, 32'h0001_0000, 32'h0001_0003, 4'd3);
      chk("op10_illegal", 64'(bus.illegal_op), 64'd1);
`endif

      // random backpressure on a back-to-back ADD stream
      bp_mode = 1'b1;
      for (int i = 0; i < 8; i++) send(4'd0, $urandom, $urandom, 4'(i));
      repeat (6) @(posedge clk);
      bp_mode = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 100) begin @(posedge clk); k++; end
      #1;
      chk("drain_empty", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
      chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

`ifdef ALU_MUL_EN
      send(4'd10, 32'h0001_0000, 32'h0001_0003, 4'd5);
      k = 0;
      while (!bus.out_valid && k < 40) begin
         chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge clk); #1;
         k++;
      end
      chk("mul_latency", 64'(k), 64'd33);
      @(posedge clk); #1;

      send(4'd10, 32'hDEAD_BEEF, 32'h0000_1234, 4'd6);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("midmul_rst_outputs", 64'({bus.out_valid, cur_out()}), 64'd0);
      chk("midmul_rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      send(4'd0, 32'd40, 32'd2, 4'd7);
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_drain", 64'(sb.size()), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
